cpu_seq: RTL

Self-sequencing accumulator CPU: the successor to the externally-controlled accumulator datapath. It adds a parametrised data width and memory depth, an internal control FSM, a program counter, and a fetch handshake to external program memory. It keeps the ALU operation set (arg load, memory read, NAND, shifts) and accumulator/data-memory structure, adds conditional branching, halt and error reporting, and sits directly below the top level as the complete processor.

---
 rtl/cpu_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cpu_seq.sv
// Self-sequencing accumulator CPU: fetches 4-bit-opcode instructions over a req/ack
// handshake, executes them against an accumulator and an internal data memory.
module cpu_seq #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W+3:0] imem_data,
    output logic [DATA_W-1:0] bus,
    output logic              is_zero,
    output logic              halted,
    output logic              error
);

    // Fetch handshake: imem_req is held high with imem_addr stable until the
    // clock edge that sees imem_req && imem_ack; that edge transfers imem_data
    // and imem_req drops on the following cycle. imem_ack is ignored while
    // imem_req is low.

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_LD   = 4'd2;
    localparam logic [3:0] OP_ST   = 4'd3;
    localparam logic [3:0] OP_NAND = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_JZ   = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;

    localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_inc;
    logic [3:0]        ir_op;
    logic [DATA_W-1:0] ir_arg;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_res;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] dmem [2**ADDR_W];

    assign pc_inc    = pc + 1'b1;
    assign imem_addr = pc;
    assign bus       = acc;
    assign mem_addr  = ir_arg[ADDR_W-1:0];
    assign mem_we    = (state == S_EXEC) && (ir_op == OP_ST);

    // Shift amounts use the full argument; anything past the word width clears acc.
    always_comb begin
        alu_res = acc;
        case (ir_op)
            OP_LDI:  alu_res = ir_arg;
            OP_SHL:  alu_res = (ir_arg >= SHIFT_LIM) ? '0 : (acc << ir_arg);
            OP_SHR:  alu_res = (ir_arg >= SHIFT_LIM) ? '0 : (acc >> ir_arg);
            default: alu_res = acc;
        endcase
    end

    assign mem_res = (ir_op == OP_NAND) ? ~(acc & rd_data) : rd_data;

    // Data memory has no reset; the read issued in EXEC is consumed in MEM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            dmem[mem_addr] <= acc;
        end
        rd_data <= dmem[mem_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir_op    <= OP_NOP;
            ir_arg   <= '0;
            acc      <= '0;
            is_zero  <= 1'b1;
            halted   <= 1'b0;
            error    <= 1'b0;
            imem_req <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state    <= S_FETCH;
                        pc       <= '0;
                        halted   <= 1'b0;
                        error    <= 1'b0;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir_op    <= imem_data[DATA_W+3:DATA_W];
                        ir_arg   <= imem_data[DATA_W-1:0];
                        imem_req <= 1'b0;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (ir_op)
                        OP_NOP, OP_ST: begin
                            pc       <= pc_inc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_LDI, OP_SHL, OP_SHR: begin
                            acc      <= alu_res;
                            is_zero  <= (alu_res == '0);
                            pc       <= pc_inc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_LD, OP_NAND: begin
                            state <= S_MEM;
                        end
                        OP_JMP: begin
                            pc       <= ir_arg[PC_W-1:0];
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_JZ: begin
                            pc       <= is_zero ? ir_arg[PC_W-1:0] : pc_inc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            // Illegal opcode: pc stays on the offending instruction.
                            error  <= 1'b1;
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    acc      <= mem_res;
                    is_zero  <= (mem_res == '0);
                    pc       <= pc_inc;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
